mor1kx_rf_wrport_arbiter: RTL and testbench

//  Arbitrates the single GPR write port (rfd_adr/result/rf_we) of the espresso register file between

---
 rtl/mor1kx_rf_wrport_arbiter.sv | 127 ++++++++++++
 tb/tb_mor1kx_rf_wrport_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_rf_wrport_arbiter.sv
// mor1kx_rf_wrport_arbiter: arbitrates the single GPR write port between pipeline WB, LSU and debug
//
// Grant priority is fixed: WB > LSU skid > DBG. WB is never back-pressured; the LSU result is held in
// a one-entry skid register, and if it waits too long the pipeline is stalled so the skid can drain.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   wb_we_i/wb_adr_i/wb_dat_i     pipeline writeback (always granted)
//   lsu_valid_i/lsu_adr_i/lsu_dat_i, lsu_ready_o   load result handshake into the skid
//   dbg_req_i/dbg_adr_i/dbg_dat_i, dbg_ack_o       debug write (level request, registered 1-cycle ack)
//   pipe_stall_o                  registered; pipeline holds off writeback while high
//   rf_we_o/rfd_adr_o/result_o    register-file write port
//   lsu_issue_i/lsu_issue_adr_i   issued-load tracking for the optional scoreboard
//   rfa_adr_i/rfb_adr_i, hazard_a_o/hazard_b_o     operand hazard lookup
//
// Optional feature: define MOR1KX_RF_ARB_SCOREBOARD_EN to keep one pending bit per GPR for loads in
// flight; otherwise both hazard outputs are tied low and the tracking inputs are ignored.
module mor1kx_rf_wrport_arbiter #(
    parameter int OPTION_RF_ADDR_WIDTH  = 5,
    parameter int OPTION_OPERAND_WIDTH  = 32,
    parameter int STARVE_LIMIT          = 4,
    parameter int OPTION_RF_R0_WRITABLE = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wb_we_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wb_dat_i,
    input  logic                            lsu_valid_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] lsu_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_dat_i,
    output logic                            lsu_ready_o,
    input  logic                            dbg_req_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] dbg_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dbg_dat_i,
    output logic                            dbg_ack_o,
    output logic                            pipe_stall_o,
    output logic                            rf_we_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
    input  logic                            lsu_issue_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] lsu_issue_adr_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfa_adr_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfb_adr_i,
    output logic                            hazard_a_o,
    output logic                            hazard_b_o
);
    localparam int AW = OPTION_RF_ADDR_WIDTH;
    localparam int OW = OPTION_OPERAND_WIDTH;

    logic          skid_valid;
    logic [AW-1:0] skid_adr;
    logic [OW-1:0] skid_dat;
    logic [3:0]    starve_cnt;
    logic [3:0]    starve_nxt;
    logic          starve_inc;
    logic          wb_grant;
    logic          skid_grant;
    logic          dbg_grant;
    logic          any_grant;
    logic          lsu_load;

    always_comb begin
        wb_grant   = wb_we_i;
        skid_grant = !wb_we_i && skid_valid;
        // The ack cycle blocks a regrant so one held request yields exactly one write.
        dbg_grant  = !wb_we_i && !skid_valid && dbg_req_i && !dbg_ack_o;
        any_grant  = wb_grant || skid_grant || dbg_grant;
        rfd_adr_o  = wb_grant ? wb_adr_i : skid_grant ? skid_adr : dbg_grant ? dbg_adr_i : '0;
        result_o   = wb_grant ? wb_dat_i : skid_grant ? skid_dat : dbg_grant ? dbg_dat_i : '0;
        // r0 writes still consume the slot; only the strobe to the RF is withheld.
        rf_we_o    = any_grant && (OPTION_RF_R0_WRITABLE != 0 || rfd_adr_o != '0);
        // A skid being drained this cycle can take a new entry at the same edge.
        lsu_ready_o = !skid_valid || skid_grant;
        lsu_load    = lsu_valid_i && lsu_ready_o;
        starve_inc  = skid_valid && !skid_grant;
        starve_nxt  = (starve_cnt == 4'hf) ? starve_cnt : starve_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid   <= 1'b0;
            skid_adr     <= '0;
            skid_dat     <= '0;
            starve_cnt   <= '0;
            pipe_stall_o <= 1'b0;
            dbg_ack_o    <= 1'b0;
        end else begin
            if (lsu_load) begin
                skid_adr <= lsu_adr_i;
                skid_dat <= lsu_dat_i;
            end
            skid_valid   <= lsu_load || (skid_valid && !skid_grant);
            starve_cnt   <= skid_grant ? 4'd0 : starve_inc ? starve_nxt : starve_cnt;
            // Stall rises on the edge where the wait count reaches the limit and drops after the drain.
            pipe_stall_o <= skid_grant ? 1'b0
                          : (pipe_stall_o || (starve_inc && starve_nxt >= 4'(STARVE_LIMIT)));
            dbg_ack_o    <= dbg_grant;
        end
    end

`ifdef MOR1KX_RF_ARB_SCOREBOARD_EN
    logic [(1<<AW)-1:0] pending;

    // The set is written last so an issue wins over a retire of the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (skid_grant)
                pending[skid_adr] <= 1'b0;
            if (lsu_issue_i && lsu_issue_adr_i != '0)
                pending[lsu_issue_adr_i] <= 1'b1;
        end
    end

    assign hazard_a_o = pending[rfa_adr_i] && rfa_adr_i != '0;
    assign hazard_b_o = pending[rfb_adr_i] && rfb_adr_i != '0;
`else
    logic unused_scoreboard;

    assign unused_scoreboard = ^{lsu_issue_i, lsu_issue_adr_i, rfa_adr_i, rfb_adr_i};
    assign hazard_a_o = 1'b0;
    assign hazard_b_o = 1'b0;
`endif

endmodule

// File: tb/tb_mor1kx_rf_wrport_arbiter.sv
// tb_mor1kx_rf_wrport_arbiter: directed scenarios plus a randomized run against a behavioural model
module tb_mor1kx_rf_wrport_arbiter;
    localparam int AW = 5;
    localparam int OW = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_we = 1'b0;
    logic [AW-1:0] wb_adr = '0;
    logic [OW-1:0] wb_dat = '0;
    logic          lsu_valid = 1'b0;
    logic [AW-1:0] lsu_adr = '0;
    logic [OW-1:0] lsu_dat = '0;
    logic          lsu_ready;
    logic          dbg_req = 1'b0;
    logic [AW-1:0] dbg_adr = '0;
    logic [OW-1:0] dbg_dat = '0;
    logic          dbg_ack;
    logic          pipe_stall;
    logic          rf_we;
    logic [AW-1:0] rfd_adr;
    logic [OW-1:0] result;
    logic          lsu_issue = 1'b0;
    logic [AW-1:0] issue_adr = '0;
    logic [AW-1:0] rfa_adr = '0;
    logic [AW-1:0] rfb_adr = '0;
    logic          hazard_a;
    logic          hazard_b;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mor1kx_rf_wrport_arbiter dut (
        .clk(clk), .rst(rst),
        .wb_we_i(wb_we), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
        .lsu_valid_i(lsu_valid), .lsu_adr_i(lsu_adr), .lsu_dat_i(lsu_dat), .lsu_ready_o(lsu_ready),
        .dbg_req_i(dbg_req), .dbg_adr_i(dbg_adr), .dbg_dat_i(dbg_dat), .dbg_ack_o(dbg_ack),
        .pipe_stall_o(pipe_stall),
        .rf_we_o(rf_we), .rfd_adr_o(rfd_adr), .result_o(result),
        .lsu_issue_i(lsu_issue), .lsu_issue_adr_i(issue_adr),
        .rfa_adr_i(rfa_adr), .rfb_adr_i(rfb_adr),
        .hazard_a_o(hazard_a), .hazard_b_o(hazard_b)
    );

    always @(posedge clk)
        assert (rst || !(wb_we && pipe_stall)) else $error("wb_we_i asserted while pipe_stall_o high");

    task automatic idle_inputs();
        wb_we = 0; wb_adr = 0; wb_dat = 0;
        lsu_valid = 0; lsu_adr = 0; lsu_dat = 0;
        dbg_req = 0; dbg_adr = 0; dbg_dat = 0;
        lsu_issue = 0; issue_adr = 0; rfa_adr = 0; rfb_adr = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        @(negedge clk); #1;
        checks++;
        if ({rf_we, rfd_adr, result, lsu_ready, dbg_ack, pipe_stall, hazard_a, hazard_b} !==
            {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset: got we=%b adr=%h dat=%h rdy=%b ack=%b stall=%b ha=%b hb=%b want 0,0,0,1,0,0,0,0",
                     rf_we, rfd_adr, result, lsu_ready, dbg_ack, pipe_stall, hazard_a, hazard_b);
        else passes++;
    endtask

    task automatic test_wb_only();
        @(negedge clk);
        wb_we = 1; wb_adr = 3; wb_dat = 32'hDEAD;
        #1;
        checks++;
        if ({rf_we, rfd_adr, result} !== {1'b1, 5'd3, 32'hDEAD})
            $display("FAIL wb_only: got %b/%h/%h want 1/03/0000dead", rf_we, rfd_adr, result);
        else passes++;
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if ({rf_we, rfd_adr, result} !== {1'b0, 5'd0, 32'd0})
            $display("FAIL wb_idle: got %b/%h/%h want 0/00/00000000", rf_we, rfd_adr, result);
        else passes++;
    endtask

    task automatic test_lsu_vs_wb();
        @(negedge clk);
        lsu_valid = 1; lsu_adr = 5; lsu_dat = 32'h11;
        #1;
        checks++;
        if (lsu_ready !== 1'b1) $display("FAIL lsu_accept_ready: got %b want 1", lsu_ready);
        else passes++;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            lsu_valid = 0; wb_we = 1; wb_adr = 1; wb_dat = 32'h1;
            #1;
            checks++;
            if ({lsu_ready, rf_we, rfd_adr, result} !== {1'b0, 1'b1, 5'd1, 32'h1})
                $display("FAIL lsu_blocked_c%0d: got rdy=%b we=%b adr=%h dat=%h want 0,1,01,00000001",
                         c, lsu_ready, rf_we, rfd_adr, result);
            else passes++;
        end
        @(negedge clk); wb_we = 0; #1;
        checks++;
        if ({lsu_ready, rf_we, rfd_adr, result} !== {1'b1, 1'b1, 5'd5, 32'h11})
            $display("FAIL lsu_write: got rdy=%b we=%b adr=%h dat=%h want 1,1,05,00000011",
                     lsu_ready, rf_we, rfd_adr, result);
        else passes++;
        @(negedge clk); #1;
        checks++;
        if (rf_we !== 1'b0) $display("FAIL lsu_single_write: got we=%b want 0", rf_we);
        else passes++;
        idle_inputs();
    endtask

    task automatic test_starvation();
        @(negedge clk);
        lsu_valid = 1; lsu_adr = 6; lsu_dat = 32'h66;
        for (int c = 1; c <= LIMIT; c++) begin
            @(negedge clk);
            lsu_valid = 0; wb_we = 1; wb_adr = 2; wb_dat = 32'h22;
            #1;
            checks++;
            if ({pipe_stall, rfd_adr} !== {1'b0, 5'd2})
                $display("FAIL starve_wait_c%0d: got stall=%b adr=%h want 0,02", c, pipe_stall, rfd_adr);
            else passes++;
        end
        @(negedge clk); wb_we = 0; #1;
        checks++;
        if ({pipe_stall, rf_we, rfd_adr, result} !== {1'b1, 1'b1, 5'd6, 32'h66})
            $display("FAIL starve_stall: got stall=%b we=%b adr=%h dat=%h want 1,1,06,00000066",
                     pipe_stall, rf_we, rfd_adr, result);
        else passes++;
        @(negedge clk); #1;
        checks++;
        if ({pipe_stall, rf_we} !== 2'b00)
            $display("FAIL starve_release: got stall=%b we=%b want 0,0", pipe_stall, rf_we);
        else passes++;
        idle_inputs();
    endtask

    task automatic test_dbg();
        @(negedge clk);
        dbg_req = 1; dbg_adr = 7; dbg_dat = 32'h55;
        #1;
        checks++;
        if ({rf_we, rfd_adr, result, dbg_ack} !== {1'b1, 5'd7, 32'h55, 1'b0})
            $display("FAIL dbg_write: got we=%b adr=%h dat=%h ack=%b want 1,07,00000055,0",
                     rf_we, rfd_adr, result, dbg_ack);
        else passes++;
        @(negedge clk); #1;
        checks++;
        if ({dbg_ack, rf_we} !== 2'b10)
            $display("FAIL dbg_ack: got ack=%b we=%b want 1,0", dbg_ack, rf_we);
        else passes++;
        @(negedge clk); dbg_req = 0; #1;
        checks++;
        if ({dbg_ack, rf_we} !== 2'b00)
            $display("FAIL dbg_ack_drop: got ack=%b we=%b want 0,0", dbg_ack, rf_we);
        else passes++;
        idle_inputs();
    endtask

    task automatic test_r0();
        @(negedge clk);
        lsu_valid = 1; lsu_adr = 0; lsu_dat = 32'h77;
        @(negedge clk); lsu_valid = 0; #1;
        checks++;
        if ({rf_we, lsu_ready} !== 2'b01)
            $display("FAIL r0_suppress: got we=%b rdy=%b want 0,1", rf_we, lsu_ready);
        else passes++;
        @(negedge clk); wb_we = 1; wb_adr = 1; #1;
        checks++;
        if (lsu_ready !== 1'b1) $display("FAIL r0_consumed: got rdy=%b want 1", lsu_ready);
        else passes++;
        @(negedge clk);
        wb_we = 0; lsu_valid = 1; lsu_adr = 4; lsu_dat = 32'h44;
        @(negedge clk);
        lsu_valid = 0; wb_we = 1; wb_adr = 1; dbg_req = 1; dbg_adr = 8; rst = 1;
        @(negedge clk);
        rst = 0; idle_inputs(); #1;
        checks++;
        if ({rf_we, lsu_ready, dbg_ack, pipe_stall} !== 4'b0100)
            $display("FAIL reset_flush: got we=%b rdy=%b ack=%b stall=%b want 0,1,0,0",
                     rf_we, lsu_ready, dbg_ack, pipe_stall);
        else passes++;
    endtask

    task automatic test_scoreboard();
        @(negedge clk); lsu_issue = 1; issue_adr = 9;
        @(negedge clk); lsu_issue = 0; rfa_adr = 9; rfb_adr = 9; #1;
`ifdef MOR1KX_RF_ARB_SCOREBOARD_EN
        checks++;
        if ({hazard_a, hazard_b} !== 2'b11)
            $display("FAIL sb_set: got ha=%b hb=%b want 1,1", hazard_a, hazard_b);
        else passes++;
        lsu_valid = 1; lsu_adr = 9; lsu_dat = 32'h99;
        @(negedge clk); lsu_valid = 0; #1;
        checks++;
        if ({rf_we, rfd_adr, hazard_a} !== {1'b1, 5'd9, 1'b1})
            $display("FAIL sb_retire_cycle: got we=%b adr=%h ha=%b want 1,09,1", rf_we, rfd_adr, hazard_a);
        else passes++;
        @(negedge clk); #1;
        checks++;
        if (hazard_a !== 1'b0) $display("FAIL sb_clear: got ha=%b want 0", hazard_a);
        else passes++;
        lsu_issue = 1; issue_adr = 9;
        @(negedge clk); lsu_issue = 0; lsu_valid = 1; lsu_adr = 9;
        @(negedge clk); lsu_valid = 0; lsu_issue = 1; issue_adr = 9;
        @(negedge clk); lsu_issue = 0; #1;
        checks++;
        if (hazard_a !== 1'b1) $display("FAIL sb_set_wins: got ha=%b want 1", hazard_a);
        else passes++;
        rfa_adr = 0;
        @(negedge clk); lsu_issue = 1; issue_adr = 0;
        @(negedge clk); lsu_issue = 0; #1;
        checks++;
        if (hazard_a !== 1'b0) $display("FAIL sb_r0: got ha=%b want 0", hazard_a);
        else passes++;
`else
        checks++;
        if ({hazard_a, hazard_b} !== 2'b00)
            $display("FAIL sb_disabled: got ha=%b hb=%b want 0,0", hazard_a, hazard_b);
        else passes++;
`endif
        idle_inputs();
        reset_dut();
    endtask

    task automatic test_random();
        bit            m_sv = 0;
        logic [AW-1:0] m_sadr = 0;
        logic [OW-1:0] m_sdat = 0;
        int            m_load_k = 0;
        bit            m_ack = 0;
        bit            pend [32];
        bit            exp_stall, sg, dg, exp_we, exp_ready, exp_ha, exp_hb;
        logic [AW-1:0] exp_adr;
        logic [OW-1:0] exp_dat;
        foreach (pend[i]) pend[i] = 0;
        reset_dut();
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            // A skid entry loaded in cycle L has waited k-L-1 cycles by cycle k.
            exp_stall = m_sv && (k - m_load_k - 1 >= LIMIT);
            wb_we = !exp_stall && ($urandom_range(2) == 0);
            wb_adr = AW'($urandom_range(7)); wb_dat = $urandom;
            lsu_valid = $urandom_range(1) == 1;
            lsu_adr = AW'($urandom_range(7)); lsu_dat = $urandom;
            if (m_ack) dbg_req = 0;
            else if (!dbg_req && $urandom_range(3) == 0) begin
                dbg_req = 1; dbg_adr = AW'($urandom_range(7)); dbg_dat = $urandom;
            end
            lsu_issue = $urandom_range(2) == 0; issue_adr = AW'($urandom_range(7));
            rfa_adr = AW'($urandom_range(7)); rfb_adr = AW'($urandom_range(7));
            #1;
            sg = !wb_we && m_sv;
            dg = !wb_we && !m_sv && dbg_req && !m_ack;
            exp_adr = wb_we ? wb_adr : sg ? m_sadr : dg ? dbg_adr : '0;
            exp_dat = wb_we ? wb_dat : sg ? m_sdat : dg ? dbg_dat : '0;
            exp_we = (wb_we || sg || dg) && exp_adr != 0;
            exp_ready = !m_sv || sg;
`ifdef MOR1KX_RF_ARB_SCOREBOARD_EN
            exp_ha = pend[rfa_adr] && rfa_adr != 0;
            exp_hb = pend[rfb_adr] && rfb_adr != 0;
`else
            exp_ha = 0;
            exp_hb = 0;
`endif
            checks++;
            if ({pipe_stall, dbg_ack, lsu_ready, rf_we, hazard_a, hazard_b} !==
                {exp_stall, m_ack, exp_ready, exp_we, exp_ha, exp_hb})
                $display("FAIL rand_ctrl k=%0d: got stall/ack/rdy/we/ha/hb=%b%b%b%b%b%b want %b%b%b%b%b%b", k,
                         pipe_stall, dbg_ack, lsu_ready, rf_we, hazard_a, hazard_b,
                         exp_stall, m_ack, exp_ready, exp_we, exp_ha, exp_hb);
            else passes++;
            checks++;
            if ({rfd_adr, result} !== {exp_adr, exp_dat})
                $display("FAIL rand_data k=%0d: got %h/%h want %h/%h", k, rfd_adr, result, exp_adr, exp_dat);
            else passes++;
            if (sg) pend[m_sadr] = 0;
            if (lsu_issue && issue_adr != 0) pend[issue_adr] = 1;
            if (lsu_valid && exp_ready) begin
                m_sv = 1; m_sadr = lsu_adr; m_sdat = lsu_dat; m_load_k = k;
            end else if (sg) m_sv = 0;
            m_ack = dg;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_lsu_vs_wb();
        test_starvation();
        test_dbg();
        test_r0();
        test_scoreboard();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
